crc10_gen: RTL and testbench
============================

Name: crc10_gen

Overview:
Transmit-side CRC10 generator/inserter for the 4-lane frame format consumed by the crc10 checker. It accepts payload beats carrying blocks 1-4 at 15/15/16/16 bits per beat. It runs four independent CRC10s and, on beat 25, merges the remaining payload bits with all four CRCs and the tail nibble. It drives crc10_en, crc10_data_out and frame_tail_flag with the exact framing the checker expects.

Parameters:
POLY, 10'b1000110011, CRC10 generator polynomial (implied x^10), init 0, MSB-first, no reflection, no final XOR
TAIL, 4'b0000, tail nibble placed in the lowest 4 bits of group4 on the tail beat
BEATS, 26, beats per frame (0..24 body, 25 tail); fixed, not for override

Ports:
clk_390p625M  in  1  single clock
rst  in  1  synchronous, active-high reset
payload_valid  in  1  payload beat present this cycle
payload_sof  in  1  qualifies beat 0 of a frame (valid only with payload_valid)
payload_data  in  62  {g1[14:0],g2[14:0],g3[15:0],g4[15:0]}; on beat 25 only g1 and g2[14:12] are meaningful
crc_err_inject  in  1  sampled on the tail beat; inverts crc_group1[0] before insertion
crc10_en  out  1  output beat valid
crc10_data_out  out  62  frame beat, same packing as payload_data
frame_tail_flag  out  1  high with crc10_en on beat 25 only
frame_cnt  out  16  completed frames, wraps
drop_cnt  out  8  aborted or orphan beats/frames, saturates at 8'hFF

Behaviour:
- Reset (rst=1 at a clock edge): all outputs 0, state IDLE, beat_cnt 0, all CRC registers 0. Reset has priority over every other input.
- Latency: one cycle, registered. Output beat N appears the cycle after input beat N. No backpressure; gaps (payload_valid=0) give crc10_en=0 and crc10_data_out hold, with CRC and counter frozen.
- CRC datapath: per lane, crc_next = step(crc, data, W), bit-serial equivalent MSB-first. Lanes 1 and 2 use W=15, lanes 3 and 4 use W=16.
  - Tail beat: lane1 W=15 (last 15 bits of block1); lane2 W=3 (g2[14:12], last 3 bits of block2); lanes 3 and 4 take no data.
  - Block1 = 390 bits, block2 = 378, block3/4 = 400.
- Tail beat composition, using the final CRCs that include this beat's data:
  - g1 = payload g1
  - g2 = {payload g2[14:12], crc1[9:0], crc2[9:8]}
  - g3 = {crc2[7:0], crc3[9:2]}
  - g4 = {crc3[1:0], crc4[9:0], TAIL}
- FSM states IDLE, BODY, TAIL:
  - IDLE: valid&sof → emit beat 0, seed CRCs from 0, beat_cnt=1, go BODY. valid&~sof → beat discarded (no output), drop_cnt++.
  - BODY: valid&~sof → emit, beat_cnt++. The accepted beat with beat_cnt==24 moves to TAIL.
  - TAIL: valid&~sof → emit composed tail beat with frame_tail_flag=1, frame_cnt++, CRCs cleared, go IDLE.
  - sof in BODY or TAIL → restart. The partial frame is abandoned (already-emitted beats are not recalled) and drop_cnt++. The current beat is processed as beat 0 from CRC 0.
- Back-to-back frames: sof on the cycle immediately after a tail beat is legal with no gap. frame_cnt wraps 16'hFFFF→0.

Decomposition:
- Package crc10_pkg:
  - POLY and TAIL constants
  - beat width constants (15/15/16/16, total 62)
  - lane struct typedef for payload/output packing, shared with the crc10 checker
  - FSM state enum
- Sub-module crc10_step: combinational, parameter W. Computes crc_out from crc_in and data[W-1:0] MSB-first; used for the W=15/16 instances. Lane 2 on the tail beat uses a W=3 instance or the W=15 instance with masked length.

Test Plan:
- All-zero frame, 26 beats → beats 0-24 output = 0; tail beat = 62'h0, frame_tail_flag=1 only on that beat, frame_cnt=1.
- block4 = 399 zeros followed by 1 (last body beat g4=16'h0001), others zero → crc4=10'h233, tail g4=16'h2330, g2=g3=0.
- block3 last bit = 1, others zero → crc3=10'h233, tail g3=16'h008C, g4=16'hC000.
- Repeating patterns block1 = 26×15'h3AD2, block2 = 25×15'h162B followed by 3'b010, block3 = 25×16'hE79A, block4 = 25×16'h3B61 → tail beat equals the bit-serial model. Looping the output into crc10 gives check_result pass and error_packet_cnt = 0.
- All-zero frame with crc_err_inject=1 on the tail beat → tail g2 = 15'h0004. The crc10 checker counts error_packet_cnt = 1.
- sof asserted at beat 10, then a full clean frame → drop_cnt=1 and the second frame's CRCs are correct. Separately, an orphan beat in IDLE gives drop_cnt=1 with no output; rst mid-frame gives all outputs 0 the next cycle.

Source files
------------

// File: rtl/crc10_pkg.sv
// rtl/crc10_pkg.sv - shared CRC10 framing constants, beat packing and FSM states
package crc10_pkg;

    // Generator polynomial without the implied x^10 term; init 0, MSB-first,
    // no reflection, no final XOR.
    localparam logic [9:0] POLY = 10'b1000110011;
    // Nibble placed in the low 4 bits of group4 on the tail beat.
    localparam logic [3:0] TAIL = 4'b0000;

    localparam int G1_W      = 15;
    localparam int G2_W      = 15;
    localparam int G3_W      = 16;
    localparam int G4_W      = 16;
    localparam int BEAT_W    = G1_W + G2_W + G3_W + G4_W;
    // Only the top 3 bits of group2 carry block2 data on the tail beat.
    localparam int TAIL_G2_W = 3;

    // Beats 0..24 are body, beat 25 is the tail.
    localparam int BEATS     = 26;
    localparam int LAST_BODY = BEATS - 2;

    // Packing shared with the crc10 checker: {g1, g2, g3, g4}, g1 in the MSBs.
    typedef struct packed {
        logic [G1_W-1:0] g1;
        logic [G2_W-1:0] g2;
        logic [G3_W-1:0] g3;
        logic [G4_W-1:0] g4;
    } lane_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BODY,
        ST_TAIL
    } state_t;

endpackage

// File: rtl/crc10_step.sv
// rtl/crc10_step.sv - combinational W-bit CRC10 update, MSB-first
//
// Ports:
//   crc_in  - current CRC register value
//   data    - W data bits, data[W-1] is consumed first
//   crc_out - CRC after absorbing all W bits
module crc10_step
    import crc10_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [9:0]   crc_in,
    input  logic [W-1:0] data,
    output logic [9:0]   crc_out
);

    // Unrolled bit-serial LFSR: feedback is the outgoing MSB XOR the next data bit.
    function automatic logic [9:0] step(input logic [9:0] crc, input logic [W-1:0] d);
        logic [9:0] c;
        logic       fb;
        c = crc;
        for (int i = W - 1; i >= 0; i--) begin
            fb = c[9] ^ d[i];
            c  = {c[8:0], 1'b0} ^ (fb ? POLY : 10'd0);
        end
        return c;
    endfunction

    assign crc_out = step(crc_in, data);

endmodule

// File: rtl/crc10_gen.sv
// rtl/crc10_gen.sv - transmit CRC10 generator/inserter for the 4-lane 26-beat frame
//
// Ports:
//   clk_390p625M    - clock
//   rst             - synchronous active-high reset
//   payload_valid   - payload beat present
//   payload_sof     - beat 0 of a frame (with payload_valid)
//   payload_data    - {g1,g2,g3,g4} payload beat
//   crc_err_inject  - on the tail beat, flips crc1[0] before insertion
//   crc10_en        - output beat valid (one cycle after the input beat)
//   crc10_data_out  - output beat, same packing; holds across gaps
//   frame_tail_flag - marks the tail beat
//   frame_cnt       - completed frames, wraps
//   drop_cnt        - aborted frames and orphan beats, saturates at 8'hFF
module crc10_gen
    import crc10_pkg::*;
(
    input  logic              clk_390p625M,
    input  logic              rst,
    input  logic              payload_valid,
    input  logic              payload_sof,
    input  logic [BEAT_W-1:0] payload_data,
    input  logic              crc_err_inject,
    output logic              crc10_en,
    output logic [BEAT_W-1:0] crc10_data_out,
    output logic              frame_tail_flag,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        drop_cnt
);

    state_t      state_q, state_d;
    logic [4:0]  beat_q, beat_d;
    logic [9:0]  crc1_q, crc2_q, crc3_q, crc4_q;
    logic [9:0]  crc1_d, crc2_d, crc3_d, crc4_d;
    logic [9:0]  crc1_in, crc2_in, crc3_in, crc4_in;
    logic [9:0]  crc1_nx, crc2_nx, crc2_tail_nx, crc3_nx, crc4_nx;
    logic [9:0]  crc1_fin;
    logic        emit, tail_sel, drop_inc, frame_inc;
    lane_beat_t  in_beat, tail_beat;

    assign in_beat = payload_data;

    // A start-of-frame beat always restarts every lane from a zero CRC.
    assign crc1_in = payload_sof ? 10'd0 : crc1_q;
    assign crc2_in = payload_sof ? 10'd0 : crc2_q;
    assign crc3_in = payload_sof ? 10'd0 : crc3_q;
    assign crc4_in = payload_sof ? 10'd0 : crc4_q;

    crc10_step #(.W(G1_W))      u_step1  (.crc_in(crc1_in), .data(in_beat.g1), .crc_out(crc1_nx));
    crc10_step #(.W(G2_W))      u_step2  (.crc_in(crc2_in), .data(in_beat.g2), .crc_out(crc2_nx));
    crc10_step #(.W(TAIL_G2_W)) u_step2t (.crc_in(crc2_in), .data(in_beat.g2[G2_W-1 -: TAIL_G2_W]),
                                          .crc_out(crc2_tail_nx));
    crc10_step #(.W(G3_W))      u_step3  (.crc_in(crc3_in), .data(in_beat.g3), .crc_out(crc3_nx));
    crc10_step #(.W(G4_W))      u_step4  (.crc_in(crc4_in), .data(in_beat.g4), .crc_out(crc4_nx));

    // Tail composition uses CRCs that already include this beat's data;
    // lanes 3 and 4 take no data on the tail so their registers are final.
    assign crc1_fin     = crc1_nx ^ {9'd0, crc_err_inject};
    assign tail_beat.g1 = in_beat.g1;
    assign tail_beat.g2 = {in_beat.g2[G2_W-1 -: TAIL_G2_W], crc1_fin, crc2_tail_nx[9:8]};
    assign tail_beat.g3 = {crc2_tail_nx[7:0], crc3_q[9:2]};
    assign tail_beat.g4 = {crc3_q[1:0], crc4_q, TAIL};

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        crc1_d    = crc1_q;
        crc2_d    = crc2_q;
        crc3_d    = crc3_q;
        crc4_d    = crc4_q;
        emit      = 1'b0;
        tail_sel  = 1'b0;
        drop_inc  = 1'b0;
        frame_inc = 1'b0;
        if (payload_valid) begin
            if (payload_sof) begin
                // Any sof starts a new frame; a frame in flight is abandoned.
                emit     = 1'b1;
                state_d  = ST_BODY;
                beat_d   = 5'd1;
                crc1_d   = crc1_nx;
                crc2_d   = crc2_nx;
                crc3_d   = crc3_nx;
                crc4_d   = crc4_nx;
                drop_inc = (state_q != ST_IDLE);
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        drop_inc = 1'b1;
                    end
                    ST_BODY: begin
                        emit   = 1'b1;
                        beat_d = beat_q + 5'd1;
                        crc1_d = crc1_nx;
                        crc2_d = crc2_nx;
                        crc3_d = crc3_nx;
                        crc4_d = crc4_nx;
                        if (beat_q == 5'(LAST_BODY)) begin
                            state_d = ST_TAIL;
                        end
                    end
                    ST_TAIL: begin
                        emit      = 1'b1;
                        tail_sel  = 1'b1;
                        frame_inc = 1'b1;
                        beat_d    = 5'd0;
                        crc1_d    = 10'd0;
                        crc2_d    = 10'd0;
                        crc3_d    = 10'd0;
                        crc4_d    = 10'd0;
                        state_d   = ST_IDLE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_390p625M) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            beat_q          <= 5'd0;
            crc1_q          <= 10'd0;
            crc2_q          <= 10'd0;
            crc3_q          <= 10'd0;
            crc4_q          <= 10'd0;
            crc10_en        <= 1'b0;
            crc10_data_out  <= '0;
            frame_tail_flag <= 1'b0;
            frame_cnt       <= 16'd0;
            drop_cnt        <= 8'd0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            crc1_q          <= crc1_d;
            crc2_q          <= crc2_d;
            crc3_q          <= crc3_d;
            crc4_q          <= crc4_d;
            crc10_en        <= emit;
            frame_tail_flag <= tail_sel;
            if (emit) begin
                crc10_data_out <= tail_sel ? tail_beat : payload_data;
            end
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (drop_inc && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_crc10_gen.sv
// tb/tb_crc10_gen.sv - self-checking bench for crc10_gen
`timescale 1ns/1ps
module tb_crc10_gen;

    logic        clk_390p625M = 1'b0;
    logic        rst;
    logic        payload_valid;
    logic        payload_sof;
    logic [61:0] payload_data;
    logic        crc_err_inject;
    logic        crc10_en;
    logic [61:0] crc10_data_out;
    logic        frame_tail_flag;
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;

    crc10_gen dut (
        .clk_390p625M    (clk_390p625M),
        .rst             (rst),
        .payload_valid   (payload_valid),
        .payload_sof     (payload_sof),
        .payload_data    (payload_data),
        .crc_err_inject  (crc_err_inject),
        .crc10_en        (crc10_en),
        .crc10_data_out  (crc10_data_out),
        .frame_tail_flag (frame_tail_flag),
        .frame_cnt       (frame_cnt),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk_390p625M = ~clk_390p625M;

    int          total = 0;
    int          bad   = 0;
    int          exp_frames;
    int          exp_drop;
    logic [62:0] out_q[$];
    logic [61:0] fr[26];

    typedef struct {
        logic [15:0] g3_last;
        logic [15:0] g4_last;
        logic        inj;
        logic [61:0] exp_tail;
    } vec_t;
    vec_t vecs[4];

    always @(negedge clk_390p625M) begin
        if (crc10_en) out_q.push_back({frame_tail_flag, crc10_data_out});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // CRC as the remainder of M(x)*x^10 divided by G(x), by polynomial long division.
    function automatic logic [9:0] crc_ld(input bit m[$]);
        bit          w[$];
        logic [10:0] g;
        logic [9:0]  r;
        g = 11'b110_0011_0011;
        w = m;
        repeat (10) w.push_back(1'b0);
        for (int i = 0; i < m.size(); i++) begin
            if (w[i]) begin
                for (int j = 0; j < 11; j++) w[i+j] = w[i+j] ^ g[10-j];
            end
        end
        for (int j = 0; j < 10; j++) r[9-j] = w[m.size()+j];
        return r;
    endfunction

    // Builds the four block bitstreams from the frame and composes the tail beat.
    function automatic logic [61:0] model_tail(input logic inj);
        bit         b1[$], b2[$], b3[$], b4[$];
        logic [9:0] c1, c2, c3, c4;
        for (int k = 0; k < 26; k++) begin
            for (int i = 14; i >= 0; i--) b1.push_back(fr[k][47+i]);
            if (k < 25) begin
                for (int i = 14; i >= 0; i--) b2.push_back(fr[k][32+i]);
                for (int i = 15; i >= 0; i--) b3.push_back(fr[k][16+i]);
                for (int i = 15; i >= 0; i--) b4.push_back(fr[k][i]);
            end else begin
                for (int i = 14; i >= 12; i--) b2.push_back(fr[k][32+i]);
            end
        end
        c1 = crc_ld(b1) ^ {9'd0, inj};
        c2 = crc_ld(b2);
        c3 = crc_ld(b3);
        c4 = crc_ld(b4);
        return {fr[25][61:47], fr[25][46:44], c1, c2[9:8], c2[7:0], c3[9:2], c3[1:0], c4, 4'b0000};
    endfunction

    function automatic logic [61:0] rnd62();
        return 62'({$urandom(), $urandom()});
    endfunction

    task automatic drive_beat(input logic [61:0] d, input logic sof, input logic inj);
        payload_valid  = 1'b1;
        payload_sof    = sof;
        payload_data   = d;
        crc_err_inject = inj;
        @(posedge clk_390p625M);
        #1;
        payload_valid  = 1'b0;
        payload_sof    = 1'b0;
        crc_err_inject = 1'b0;
        payload_data   = rnd62();
    endtask

    task automatic idle_cycle();
        @(posedge clk_390p625M);
        #1;
    endtask

    task automatic flush();
        @(negedge clk_390p625M);
        #1;
    endtask

    task automatic run_frame(input logic inj, input int gap_pct, output logic [61:0] tail_act);
        int   base;
        logic body_ok;
        base = out_q.size();
        for (int k = 0; k < 26; k++) begin
            drive_beat(fr[k], k == 0, (k == 25) ? inj : 1'b0);
            if (k < 25 && gap_pct > 0 && $urandom_range(99, 0) < gap_pct) idle_cycle();
        end
        flush();
        exp_frames++;
        tail_act = '0;
        chk("frame_beats", 64'(out_q.size() - base), 64'd26);
        if (out_q.size() - base == 26) begin
            body_ok = 1'b1;
            for (int k = 0; k < 25; k++) begin
                if (out_q[base+k] !== {1'b0, fr[k]}) body_ok = 1'b0;
            end
            chk("body_passthru", 64'(body_ok), 64'd1);
            tail_act = out_q[base+25][61:0];
            chk("tail_flag", 64'(out_q[base+25][62]), 64'd1);
            chk("tail_model", 64'(tail_act), 64'(model_tail(inj)));
        end
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames[15:0]));
        chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    endtask

    initial begin
        logic [61:0] tail;
        logic [61:0] hold_beat;
        int          base;

        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 62'h0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 62'h2330};
        vecs[2] = '{16'h0001, 16'h0000, 1'b0, 62'h008C_C000};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 62'h4_0000_0000};

        rst            = 1'b1;
        payload_valid  = 1'b0;
        payload_sof    = 1'b0;
        payload_data   = '0;
        crc_err_inject = 1'b0;
        exp_frames     = 0;
        exp_drop       = 0;
        repeat (3) @(posedge clk_390p625M);
        #1;
        chk("rst_en", 64'(crc10_en), 64'd0);
        chk("rst_data", 64'(crc10_data_out), 64'd0);
        chk("rst_tail", 64'(frame_tail_flag), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        idle_cycle();

        // Directed single-bit frames with known tail values.
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 26; k++) fr[k] = '0;
            fr[24][31:16] = vecs[v].g3_last;
            fr[24][15:0]  = vecs[v].g4_last;
            run_frame(vecs[v].inj, 0, tail);
            chk($sformatf("vec%0d_tail", v), 64'(tail), 64'(vecs[v].exp_tail));
        end

        // Repeating pattern; unused tail-beat bits are randomised.
        for (int k = 0; k < 25; k++) fr[k] = {15'h3AD2, 15'h162B, 16'hE79A, 16'h3B61};
        fr[25] = {15'h3AD2, 3'b010, 44'({$urandom(), $urandom()})};
        run_frame(1'b0, 0, tail);

        // Random frames with random gaps and error injection, back to back.
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 26; k++) fr[k] = rnd62();
            run_frame(1'($urandom_range(1, 0)), (n < 5) ? 30 : 0, tail);
        end

        // sof at beat 10 restarts the frame.
        for (int k = 0; k < 10; k++) drive_beat(rnd62(), k == 0, 1'b0);
        flush();
        exp_drop++;
        for (int k = 0; k < 26; k++) fr[k] = rnd62();
        run_frame(1'b0, 0, tail);

        // sof arriving in place of the tail beat also restarts.
        for (int k = 0; k < 25; k++) drive_beat(rnd62(), k == 0, 1'b0);
        flush();
        exp_drop++;
        for (int k = 0; k < 26; k++) fr[k] = rnd62();
        run_frame(1'b1, 20, tail);

        // Orphan beat in IDLE: no output, counted as dropped.
        base = out_q.size();
        drive_beat(rnd62(), 1'b0, 1'b0);
        flush();
        exp_drop++;
        chk("orphan_no_output", 64'(out_q.size() - base), 64'd0);
        chk("orphan_drop_cnt", 64'(drop_cnt), 64'(exp_drop));

        // Gap after beat 0: enable drops, data holds.
        hold_beat = rnd62();
        drive_beat(hold_beat, 1'b1, 1'b0);
        idle_cycle();
        idle_cycle();
        flush();
        chk("gap_en", 64'(crc10_en), 64'd0);
        chk("gap_hold", 64'(crc10_data_out), 64'(hold_beat));
        exp_drop++;
        for (int k = 0; k < 26; k++) fr[k] = rnd62();
        run_frame(1'b0, 0, tail);

        // Reset mid-frame beats a concurrent sof beat.
        for (int k = 0; k < 5; k++) drive_beat(rnd62(), k == 0, 1'b0);
        rst           = 1'b1;
        payload_valid = 1'b1;
        payload_sof   = 1'b1;
        payload_data  = rnd62();
        @(posedge clk_390p625M);
        #1;
        rst           = 1'b0;
        payload_valid = 1'b0;
        payload_sof   = 1'b0;
        chk("midrst_en", 64'(crc10_en), 64'd0);
        chk("midrst_data", 64'(crc10_data_out), 64'd0);
        chk("midrst_tail", 64'(frame_tail_flag), 64'd0);
        chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
        exp_frames = 0;
        exp_drop   = 0;
        for (int k = 0; k < 26; k++) fr[k] = rnd62();
        run_frame(1'b0, 10, tail);

        // drop_cnt saturates.
        repeat (260) drive_beat(rnd62(), 1'b0, 1'b0);
        flush();
        chk("drop_saturate", 64'(drop_cnt), 64'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
